// File: rtl/aes_inv_cipher_if.sv
// rtl/aes_inv_cipher_if.sv - load/ready handshake, ciphertext/plaintext and key schedule bundle for aes_inv_cipher
interface aes_inv_cipher_if #(
  parameter int Nk = 4
);
  localparam int Nr = Nk + 6;

  logic [127:0] k_sch [0:Nr];
  logic         load;
  logic [127:0] ct;
  logic         ready;
  logic [127:0] pt;
  logic         valid;

  modport master (
    output k_sch,
    output load,
    output ct,
    input  ready,
    input  pt,
    input  valid
  );

  modport slave (
    input  k_sch,
    input  load,
    input  ct,
    output ready,
    output pt,
    output valid
  );
endinterface

// File: rtl/aes_inv_cipher.sv
// rtl/aes_inv_cipher.sv - iterative AES inverse cipher, one round per clock (optional macro AES_INV_EQUIV_EN)
module aes_inv_cipher #(
  parameter int Nk = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  aes_inv_cipher_if.slave bus_if
);
  localparam int Nr = Nk + 6;
  localparam int RW = $clog2(Nr + 1);

  generate
    if (!(Nk == 4 || Nk == 6 || Nk == 8)) begin : g_bad_nk
      $error("aes_inv_cipher: Nk must be 4, 6 or 8");
    end
  endgenerate

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fsm_e;

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (maps 0 to 0, as the S-box needs)
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = a;
    acc = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  // Inverse S-box: undo the affine map, then invert in the field
  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    logic [7:0] y;
    y = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    return gf_inv(y);
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = inv_sbox(s[127-8*i -: 8]);
    return o;
  endfunction

  // Byte i of the block is state row i%4, column i/4
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(r+4*((c+r)%4)) -: 8] = s[127-8*(r+4*c) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
      o[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
      o[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
      o[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end
    return o;
  endfunction

  fsm_e          fsm_q, fsm_d;
  logic [RW-1:0] rnd_q, rnd_d;
  logic [127:0]  st_q, st_d;
  logic [127:0]  pt_q, pt_d;
  logic          valid_q, valid_d;

  logic          last_round;
  logic [127:0]  key_sel;
  logic [127:0]  round_out;
`ifdef AES_INV_EQUIV_EN
  logic [127:0]  sub_shift;
  logic [127:0]  dk_sel;
`else
  logic [127:0]  ark;
`endif

  // Shared round datapath; the final round (rnd==0) skips InvMixColumns
  always_comb begin
    last_round = (rnd_q == '0);
    key_sel    = bus_if.k_sch[rnd_q];
`ifdef AES_INV_EQUIV_EN
    // Middle-round key pre-mixed so the key add sits at the end like the forward cipher
    sub_shift  = inv_shift_rows(inv_sub_bytes(st_q));
    dk_sel     = inv_mix_columns(key_sel);
    round_out  = last_round ? (sub_shift ^ key_sel) : (inv_mix_columns(sub_shift) ^ dk_sel);
`else
    ark        = inv_sub_bytes(inv_shift_rows(st_q)) ^ key_sel;
    round_out  = last_round ? ark : inv_mix_columns(ark);
`endif
  end

  // Next-state logic: accept in IDLE, count rounds down in RUN, publish at rnd==0
  always_comb begin
    fsm_d   = fsm_q;
    rnd_d   = rnd_q;
    st_d    = st_q;
    pt_d    = pt_q;
    valid_d = 1'b0;
    case (fsm_q)
      IDLE: begin
        if (bus_if.load) begin
          st_d  = bus_if.ct ^ bus_if.k_sch[Nr];
          rnd_d = RW'(Nr - 1);
          fsm_d = RUN;
        end
      end
      RUN: begin
        if (last_round) begin
          pt_d    = round_out;
          valid_d = 1'b1;
          fsm_d   = IDLE;
        end else begin
          st_d  = round_out;
          rnd_d = rnd_q - 1'b1;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  // State registers; reset aborts any block in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= IDLE;
      rnd_q   <= '0;
      st_q    <= '0;
      pt_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      rnd_q   <= rnd_d;
      st_q    <= st_d;
      pt_q    <= pt_d;
      valid_q <= valid_d;
    end
  end

  assign bus_if.ready = (fsm_q == IDLE);
  assign bus_if.pt    = pt_q;
  assign bus_if.valid = valid_q;
endmodule
